// File: rtl/bus_decoder_nx_pkg.sv
// Shared types and default address map for the core-to-peripheral bus decoder.
// Slave order: flash, iof, gpio, pwm0, i2c0, spi master0, timer0, uart0, debug,
// reg_to_pin, spi slave0, dmem, dmem2, imem.
package pck_bus_decoder;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

  localparam int DEF_N_SLAVES  = 14;
  localparam int DEF_ADDR_W    = 32;
  localparam int BUS_READ_MASK = 0;

  typedef logic [DEF_ADDR_W-1:0] addr_tbl_t [DEF_N_SLAVES];

  // dmem (64 KiB) sits inside the dmem2 window; the lower index claims the overlap
  localparam addr_tbl_t DEF_SLV_BASE = '{
    32'h2000_0000, 32'h0300_0000, 32'h0400_0000, 32'h0500_0000,
    32'h0600_0000, 32'h0700_0000, 32'h0800_0000, 32'h0900_0000,
    32'h0A00_0000, 32'h0B00_0000, 32'h0D00_0000, 32'h8000_0000,
    32'h8000_0000, 32'h0000_0000
  };

  localparam addr_tbl_t DEF_SLV_MASK = '{
    32'hF000_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000,
    32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000,
    32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_0000,
    32'hFFF0_0000, 32'hFFF0_0000
  };

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_decoder_nx_if.sv
// Bus bundle between the core data port, the decoder and the slave ports.
// Signal names are from the decoder's point of view.
interface bus_decoder_nx_if
  import pck_bus_decoder::*;
#(
  parameter int N_SLAVES = DEF_N_SLAVES,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = 32
);
  logic                       i_req;
  logic [ADDR_W-1:0]          i_addr;
  logic [DATA_W-1:0]          i_wdata;
  logic [DATA_W/8-1:0]        i_wmask;
  logic [DATA_W-1:0]          o_rdata;
  logic                       o_ack;
  logic                       o_err;
  logic [N_SLAVES-1:0]        o_sel;
  logic [ADDR_W-1:0]          o_addr;
  logic [DATA_W-1:0]          o_wdata;
  logic [DATA_W/8-1:0]        o_wmask;
  logic [N_SLAVES*DATA_W-1:0] i_rdata;
  logic [N_SLAVES-1:0]        i_ack;

  modport master (
    output i_req, i_addr, i_wdata, i_wmask, i_rdata, i_ack,
    input  o_rdata, o_ack, o_err, o_sel, o_addr, o_wdata, o_wmask
  );

  modport slave (
    input  i_req, i_addr, i_wdata, i_wmask, i_rdata, i_ack,
    output o_rdata, o_ack, o_err, o_sel, o_addr, o_wdata, o_wmask
  );
endinterface

// File: rtl/bus_decoder_nx_addr_match.sv
// Parallel (base, mask) compare across all slaves with lowest-index priority.
// Purely combinational; yields hit flag, winning index and in-slave offset.
module bus_addr_match
  import pck_bus_decoder::*;
#(
  parameter int N_SLAVES = DEF_N_SLAVES,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int IDX_W    = idx_width(DEF_N_SLAVES),
  parameter logic [ADDR_W-1:0] SLV_BASE [N_SLAVES] = DEF_SLV_BASE,
  parameter logic [ADDR_W-1:0] SLV_MASK [N_SLAVES] = DEF_SLV_MASK
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] offset
);
  logic [N_SLAVES-1:0] match;

  always_comb begin
    match = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      match[k] = ((addr & SLV_MASK[k]) == SLV_BASE[k]);
    end
  end

  // Walk downward so the lowest matching index is the last one written
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    offset = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit    = 1'b1;
        idx    = IDX_W'(k);
        offset = addr & ~SLV_MASK[k];
      end
    end
  end

endmodule

// File: rtl/bus_decoder_nx.sv
// N-slave address decoder and single-outstanding transaction sequencer with
// timeout, bus-error response and debug capture of the last faulting address.
module bus_decoder_nx
  import pck_bus_decoder::*;
#(
  parameter int N_SLAVES = DEF_N_SLAVES,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 255,
  parameter int ERRCNT_W = 16,
  parameter logic [ADDR_W-1:0] SLV_BASE [N_SLAVES] = DEF_SLV_BASE,
  parameter logic [ADDR_W-1:0] SLV_MASK [N_SLAVES] = DEF_SLV_MASK
) (
  input  logic                i_clk,
  input  logic                i_rst,
  bus_decoder_nx_if.slave     bus,
  output logic [ERRCNT_W-1:0] o_err_cnt,
  output logic [ADDR_W-1:0]   o_err_addr
);
  // state | meaning
  // IDLE  | accepting i_req, address decoded combinationally
  // WAIT  | one slave selected, cycle counter running toward TIMEOUT
  // RESP  | one-cycle o_ack with captured read data
  // ERR   | first cycle logs the fault, second cycle drives o_ack + o_err

  localparam int WM_W  = DATA_W / 8;
  localparam int IDX_W = idx_width(N_SLAVES);
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [WM_W-1:0]     READ_MASK = WM_W'(BUS_READ_MASK);
  localparam logic [N_SLAVES-1:0] SEL_ONE   = N_SLAVES'(1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [ADDR_W-1:0]    offset_q;
  logic [ADDR_W-1:0]    req_addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [WM_W-1:0]      wmask_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [ERRCNT_W-1:0]  err_cnt_q;
  logic [ADDR_W-1:0]    err_addr_q;

  logic                 hit;
  logic [IDX_W-1:0]     hit_idx;
  logic [ADDR_W-1:0]    hit_offset;
  logic [DATA_W-1:0]    slv_rdata [N_SLAVES];
  logic                 ack_sel;
  logic                 err_log;
  logic                 err_resp;

  bus_addr_match #(
    .N_SLAVES (N_SLAVES),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_match (
    .addr   (bus.i_addr),
    .hit    (hit),
    .idx    (hit_idx),
    .offset (hit_offset)
  );

  for (genvar k = 0; k < N_SLAVES; k++) begin : g_rdata
    assign slv_rdata[k] = bus.i_rdata[k*DATA_W +: DATA_W];
  end

  // Only the latched slave's acknowledge can ever advance the FSM
  assign ack_sel  = bus.i_ack[idx_q];
  assign err_log  = (state_q == ERR) && (cnt_q == '0);
  assign err_resp = (state_q == ERR) && (cnt_q != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.i_req) state_d = hit ? WAIT : ERR;
      WAIT: begin
        if (ack_sel)                state_d = RESP;
        else if (cnt_q == CNT_LAST) state_d = ERR;
      end
      RESP: state_d = IDLE;
      ERR:  if (err_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_sel   = '0;
    bus.o_ack   = 1'b0;
    bus.o_err   = 1'b0;
    bus.o_rdata = '0;
    case (state_q)
      WAIT: bus.o_sel = SEL_ONE << idx_q;
      RESP: begin
        bus.o_ack   = 1'b1;
        bus.o_rdata = rdata_q;
      end
      ERR: begin
        bus.o_ack = err_resp;
        bus.o_err = err_resp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      offset_q   <= '0;
      req_addr_q <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == WAIT || state_q == ERR)
        cnt_q <= cnt_q + CNT_W'(1);

      case (state_q)
        IDLE: if (bus.i_req) begin
          req_addr_q <= bus.i_addr;
          if (hit) begin
            idx_q    <= hit_idx;
            offset_q <= hit_offset;
            wdata_q  <= bus.i_wdata;
            wmask_q  <= bus.i_wmask;
          end
        end
        WAIT: if (ack_sel)
          rdata_q <= (wmask_q == READ_MASK) ? slv_rdata[idx_q] : '0;
        ERR: if (err_log) begin
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
          err_addr_q <= req_addr_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_addr  = offset_q;
  assign bus.o_wdata = wdata_q;
  assign bus.o_wmask = wmask_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_err_addr  = err_addr_q;

endmodule

// File: tb/tb_bus_decoder_nx.sv
// Scoreboard bench for bus_decoder_nx: stimulus pushes expected responses,
// a negedge monitor pops and compares on every o_ack.
module tb_bus_decoder_nx;
  localparam int NS = 14;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int EW = 8;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] err_addr;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  exp_t          sb[$];
  exp_t          mon_e;

  bus_decoder_nx_if #(.N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_decoder_nx #(.TIMEOUT(TO), .ERRCNT_W(EW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .o_err_cnt  (err_cnt),
    .o_err_addr (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_ack === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 64'(bus.o_ack), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_rdata"}, 64'(bus.o_rdata), 64'(mon_e.rdata));
        check({mon_e.tag, "_err"}, 64'(bus.o_err), 64'(mon_e.err));
      end
    end
  end

  // exp_slave < 0: no select expected; ack_after < 0: the slave never acks
  task automatic xfer(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wmask, input int exp_slave, input int ack_after,
                      input logic [31:0] slv_data, input int spur, input logic [31:0] exp_off,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input int exp_nsel);
    int c0;
    int nsel;
    bit seen;
    logic [NS-1:0] es;
    es = '0;
    if (exp_slave >= 0) es[exp_slave] = 1'b1;
    bus.i_req   = 1'b1;
    bus.i_addr  = addr;
    bus.i_wdata = wdata;
    bus.i_wmask = wmask;
    sb.push_back('{exp_rdata, exp_err, tag});
    c0 = cyc;
    tick();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;
    bus.i_wmask = '0;
    nsel = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.o_ack === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus.o_sel !== '0) begin
          nsel++;
          check({tag, "_sel"}, 64'(bus.o_sel), 64'(es));
          if (nsel == 1) begin
            check({tag, "_addr"}, 64'(bus.o_addr), 64'(exp_off));
            check({tag, "_wdata"}, 64'(bus.o_wdata), 64'(wdata));
            check({tag, "_wmask"}, 64'(bus.o_wmask), 64'(wmask));
            if (spur >= 0) begin
              bus.i_ack[spur] = 1'b1;
              bus.i_rdata[spur*DW +: DW] = 32'hBAD0_0BAD;
            end
          end
          if (ack_after >= 0 && exp_slave >= 0 && nsel == ack_after + 1) begin
            bus.i_ack[exp_slave] = 1'b1;
            bus.i_rdata[exp_slave*DW +: DW] = slv_data;
          end
        end
        tick();
        bus.i_ack = '0;
      end
    end
    check({tag, "_ack_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(cyc - c0), 64'(exp_lat));
    check({tag, "_nsel"}, 64'(nsel), 64'(exp_nsel));
    check({tag, "_sel_at_ack"}, 64'(bus.o_sel), 64'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;
    bus.i_wmask = '0;
    bus.i_ack   = '0;
    for (int k = 0; k < NS; k++) bus.i_rdata[k*DW +: DW] = 32'hF000_0000 | 32'(k);
    repeat (3) tick();
    check("rst_sel", 64'(bus.o_sel), 64'd0);
    check("rst_ack", 64'(bus.o_ack), 64'd0);
    check("rst_err", 64'(bus.o_err), 64'd0);
    check("rst_rdata", 64'(bus.o_rdata), 64'd0);
    check("rst_addr", 64'(bus.o_addr), 64'd0);
    check("rst_errcnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    tick();

    xfer("gpio_rd", 32'h0400_0008, 32'h0, 4'b0000, 2, 0, 32'h0000_00A5, -1,
         32'h0000_0008, 32'h0000_00A5, 1'b0, 2, 1);
    xfer("uart_wr", 32'h0900_0000, 32'h0000_0041, 4'b0001, 7, 0, 32'hDEAD_BEEF, -1,
         32'h0, 32'h0, 1'b0, 2, 1);
    xfer("unmapped", 32'h0C00_0000, 32'h0, 4'b0000, -1, -1, 32'h0, -1,
         32'h0, 32'h0, 1'b1, 2, 0);
    check("unmapped_errcnt", 64'(err_cnt), 64'd1);
    check("unmapped_erraddr", 64'(err_addr), 64'h0C00_0000);
    xfer("timeout", 32'h0800_0010, 32'h0, 4'b0000, 6, -1, 32'h0, -1,
         32'h10, 32'h0, 1'b1, TO + 2, TO);
    check("timeout_errcnt", 64'(err_cnt), 64'd2);
    check("timeout_erraddr", 64'(err_addr), 64'h0800_0010);
    xfer("ack_at_limit", 32'h0800_0010, 32'h0, 4'b0000, 6, TO - 1, 32'h1234_5678, -1,
         32'h10, 32'h1234_5678, 1'b0, TO + 1, TO);
    check("ack_at_limit_errcnt", 64'(err_cnt), 64'd2);
    xfer("spurious", 32'h0400_0100, 32'h0, 4'b0000, 2, 2, 32'h5A5A_0001, 3,
         32'h100, 32'h5A5A_0001, 1'b0, 4, 3);
    xfer("flash", 32'h2ABC_DEF0, 32'h0, 4'b0000, 0, 1, 32'h0F1A_5000, -1,
         32'h0ABC_DEF0, 32'h0F1A_5000, 1'b0, 3, 2);
    xfer("dmem_prio", 32'h8000_0100, 32'h0, 4'b0000, 11, 0, 32'h0000_D11D, -1,
         32'h100, 32'h0000_D11D, 1'b0, 2, 1);
    xfer("dmem2", 32'h8001_0004, 32'hCAFE_F00D, 4'b1111, 12, 0, 32'h7777_7777, -1,
         32'h0001_0004, 32'h0, 1'b0, 2, 1);
    xfer("imem", 32'h0000_0040, 32'h0, 4'b0000, 13, 0, 32'h1357_9BDF, -1,
         32'h40, 32'h1357_9BDF, 1'b0, 2, 1);

    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0400_0020;
    tick();
    bus.i_req  = 1'b0;
    bus.i_addr = '0;
    tick();
    tick();
    check("abort_sel_wait3", 64'(bus.o_sel), 64'h4);
    check("abort_errcnt_pre", 64'(err_cnt), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_sel", 64'(bus.o_sel), 64'd0);
    check("abort_ack", 64'(bus.o_ack), 64'd0);
    check("abort_err", 64'(bus.o_err), 64'd0);
    check("abort_rdata", 64'(bus.o_rdata), 64'd0);
    check("abort_addr", 64'(bus.o_addr), 64'd0);
    check("abort_wdata", 64'(bus.o_wdata), 64'd0);
    check("abort_wmask", 64'(bus.o_wmask), 64'd0);
    check("abort_errcnt", 64'(err_cnt), 64'd0);
    check("abort_erraddr", 64'(err_addr), 64'd0);
    repeat (12) tick();
    xfer("post_abort", 32'h0400_0024, 32'h0, 4'b0000, 2, 1, 32'h0000_0C0C, -1,
         32'h24, 32'h0000_0C0C, 1'b0, 3, 2);

    for (int i = 0; i < 260; i++) begin
      xfer("sat", 32'h0C00_0000 + 32'(i * 4), 32'h0, 4'b0000, -1, -1, 32'h0, -1,
           32'h0, 32'h0, 1'b1, 2, 0);
      if (i == 253) check("sat_errcnt_254", 64'(err_cnt), 64'hFE);
    end
    check("sat_errcnt", 64'(err_cnt), 64'hFF);
    check("sat_erraddr", 64'(err_addr), 64'h0C00_040C);

    repeat (4) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
